riscv_wb_arbiter: RTL and testbench

Write-back arbiter sitting directly upstream of the integer/FP register file's two write ports. It merges three result sources onto write ports A and B:
- single-cycle EX results;
- LSU load data;
- long-latency APU/FPU results.

APU results are buffered in a small FIFO and retired into whichever port is idle. A per-register pending scoreboard tracks APU writes that are still outstanding, so the issue stage can stall on RAW/WAW hazards.

---
 rtl/riscv_wb_arbiter.sv | 116 +++++++++++
 tb/tb_riscv_wb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: EX owns port A, LSU owns port B, and buffered APU
// results retire into whichever port is idle. Tracks outstanding APU writes.
module riscv_wb_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_we_i,
   input  logic [ADDR_WIDTH-1:0]    ex_waddr_i,
   input  logic [DATA_WIDTH-1:0]    ex_wdata_i,
   input  logic                     lsu_we_i,
   input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
   input  logic                     apu_valid_i,
   output logic                     apu_ready_o,
   input  logic [ADDR_WIDTH-1:0]    apu_waddr_i,
   input  logic [DATA_WIDTH-1:0]    apu_wdata_i,
   input  logic                     apu_issue_i,
   input  logic [ADDR_WIDTH-1:0]    apu_issue_addr_i,
   output logic [2**ADDR_WIDTH-1:0] pending_o,
   output logic                     we_a_o,
   output logic [ADDR_WIDTH-1:0]    waddr_a_o,
   output logic [DATA_WIDTH-1:0]    wdata_a_o,
   output logic                     we_b_o,
   output logic [ADDR_WIDTH-1:0]    waddr_b_o,
   output logic [DATA_WIDTH-1:0]    wdata_b_o
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;
   localparam int NREG = 2**ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] r_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_data_q [FIFO_DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic [NREG-1:0]       r_pending;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop_a;
   logic                  w_pop_b;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_head_addr;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [NREG-1:0]       w_pend_nxt;

   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = apu_valid_i & ~w_full;
   assign w_head_addr = r_addr_q[r_rptr];
   assign w_head_data = r_data_q[r_rptr];

   // Head prefers port A; falls back to B only when EX is busy.
   assign w_pop_a = ~w_empty & ~ex_we_i;
   assign w_pop_b = ~w_empty & ex_we_i & ~lsu_we_i;
   assign w_pop   = w_pop_a | w_pop_b;

   assign apu_ready_o = ~w_full;
   assign pending_o   = r_pending;

   assign we_a_o    = ex_we_i | w_pop_a;
   assign waddr_a_o = ex_we_i ? ex_waddr_i : w_head_addr;
   assign wdata_a_o = ex_we_i ? ex_wdata_i : w_head_data;

   assign we_b_o    = lsu_we_i | w_pop_b;
   assign waddr_b_o = lsu_we_i ? lsu_waddr_i : w_head_addr;
   assign wdata_b_o = lsu_we_i ? lsu_wdata_i : w_head_data;

   // Set is applied after clear so a same-cycle reissue stays pending.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_pop)
         w_pend_nxt[w_head_addr] = 1'b0;
      if (apu_issue_i)
         w_pend_nxt[apu_issue_addr_i] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_pending <= '0;
      end else begin
         r_pending <= w_pend_nxt;
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_addr_q[i] <= '0;
            r_data_q[i] <= '0;
         end
      end else if (w_push) begin
         r_addr_q[r_wptr] <= apu_waddr_i;
         r_data_q[r_wptr] <= apu_wdata_i;
      end
   end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed vector table, reset corner and
// randomized traffic against a queue-based reference model.
module tb_riscv_wb_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic          ex_we;
      logic [AW-1:0] ex_a;
      logic [DW-1:0] ex_d;
      logic          lsu_we;
      logic [AW-1:0] lsu_a;
      logic [DW-1:0] lsu_d;
      logic          av;
      logic [AW-1:0] aa;
      logic [DW-1:0] ad;
      logic          iss;
      logic [AW-1:0] ia;
      logic          rdy;
      logic          wa;
      logic [AW-1:0] a_a;
      logic [DW-1:0] a_d;
      logic          wb;
      logic [AW-1:0] b_a;
      logic [DW-1:0] b_d;
      logic [63:0]   pend;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk;
   logic          rst_n;
   logic          ex_we_i;
   logic [AW-1:0] ex_waddr_i;
   logic [DW-1:0] ex_wdata_i;
   logic          lsu_we_i;
   logic [AW-1:0] lsu_waddr_i;
   logic [DW-1:0] lsu_wdata_i;
   logic          apu_valid_i;
   logic          apu_ready_o;
   logic [AW-1:0] apu_waddr_i;
   logic [DW-1:0] apu_wdata_i;
   logic          apu_issue_i;
   logic [AW-1:0] apu_issue_addr_i;
   logic [63:0]   pending_o;
   logic          we_a_o;
   logic [AW-1:0] waddr_a_o;
   logic [DW-1:0] wdata_a_o;
   logic          we_b_o;
   logic [AW-1:0] waddr_b_o;
   logic [DW-1:0] wdata_b_o;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rf [64];

   riscv_wb_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
      .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i),
      .lsu_wdata_i(lsu_wdata_i),
      .apu_valid_i(apu_valid_i), .apu_ready_o(apu_ready_o),
      .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
      .apu_issue_i(apu_issue_i), .apu_issue_addr_i(apu_issue_addr_i),
      .pending_o(pending_o),
      .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
      .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: port B written last so it wins on an address clash.
   always @(posedge clk) begin
      if (we_a_o) rf[waddr_a_o] <= wdata_a_o;
      if (we_b_o) rf[waddr_b_o] <= wdata_b_o;
   end

   function automatic vec_t V(
      input logic e, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
      input logic l, input logic [AW-1:0] la, input logic [DW-1:0] ld,
      input logic v, input logic [AW-1:0] va, input logic [DW-1:0] vd,
      input logic s, input logic [AW-1:0] sa,
      input logic r,
      input logic wa, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
      input logic wb, input logic [AW-1:0] ya, input logic [DW-1:0] yd,
      input logic [63:0] p);
      vec_t t;
      t.ex_we = e;  t.ex_a = ea;  t.ex_d = ed;
      t.lsu_we = l; t.lsu_a = la; t.lsu_d = ld;
      t.av = v;     t.aa = va;    t.ad = vd;
      t.iss = s;    t.ia = sa;    t.rdy = r;
      t.wa = wa;    t.a_a = xa;   t.a_d = xd;
      t.wb = wb;    t.b_a = ya;   t.b_d = yd;
      t.pend = p;
      return t;
   endfunction

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      ex_we_i = v.ex_we;   ex_waddr_i = v.ex_a;   ex_wdata_i = v.ex_d;
      lsu_we_i = v.lsu_we; lsu_waddr_i = v.lsu_a; lsu_wdata_i = v.lsu_d;
      apu_valid_i = v.av;  apu_waddr_i = v.aa;    apu_wdata_i = v.ad;
      apu_issue_i = v.iss; apu_issue_addr_i = v.ia;
   endtask

   task automatic compare(input vec_t v);
      chk("ready", 64'(apu_ready_o), 64'(v.rdy));
      chk("we_a", 64'(we_a_o), 64'(v.wa));
      if (v.wa) begin
         chk("waddr_a", 64'(waddr_a_o), 64'(v.a_a));
         chk("wdata_a", 64'(wdata_a_o), 64'(v.a_d));
      end
      chk("we_b", 64'(we_b_o), 64'(v.wb));
      if (v.wb) begin
         chk("waddr_b", 64'(waddr_b_o), 64'(v.b_a));
         chk("wdata_b", 64'(wdata_b_o), 64'(v.b_d));
      end
      chk("pending", pending_o, v.pend);
   endtask

   task automatic cyc(input vec_t v);
      drive(v);
      #3;
      compare(v);
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] B33 = 64'h1 << 33;
   localparam logic [63:0] B40 = 64'h1 << 40;

   vec_t tbl [28];
   vec_t idle;

   ent_t        q[$];
   logic [63:0] pm;

   initial begin
      idle = V(0,0,0, 0,0,0, 0,0,0, 0,0, 1, 0,0,0, 0,0,0, 64'h0);
      tbl[0]  = V(1,5,'h11, 1,5,'h22, 0,0,0, 0,0, 1, 1,5,'h11, 1,5,'h22, 0);
      tbl[1]  = V(0,0,0, 0,0,0, 0,0,0, 1,33, 1, 0,0,0, 0,0,0, 0);
      tbl[2]  = V(0,0,0, 0,0,0, 0,0,0, 0,0, 1, 0,0,0, 0,0,0, B33);
      tbl[3]  = tbl[2];
      tbl[4]  = V(0,0,0, 0,0,0, 1,33,'hDEADBEEF, 0,0,
                  1, 0,0,0, 0,0,0, B33);
      tbl[5]  = V(0,0,0, 0,0,0, 0,0,0, 0,0,
                  1, 1,33,'hDEADBEEF, 0,0,0, B33);
      tbl[6]  = idle;
      tbl[7]  = V(1,1,1, 1,2,2, 1,10,'hA0, 0,0, 1, 1,1,1, 1,2,2, 0);
      tbl[8]  = V(1,1,1, 1,2,2, 1,11,'hA1, 0,0, 1, 1,1,1, 1,2,2, 0);
      tbl[9]  = V(1,1,1, 1,2,2, 1,12,'hA2, 0,0, 0, 1,1,1, 1,2,2, 0);
      tbl[10] = V(1,1,1, 0,0,0, 1,12,'hA2, 0,0, 0, 1,1,1, 1,10,'hA0, 0);
      tbl[11] = V(1,1,1, 0,0,0, 1,12,'hA2, 0,0, 1, 1,1,1, 1,11,'hA1, 0);
      tbl[12] = V(1,1,1, 0,0,0, 0,0,0, 0,0, 1, 1,1,1, 1,12,'hA2, 0);
      tbl[13] = idle;
      tbl[14] = V(0,0,0, 0,0,0, 0,0,0, 1,40, 1, 0,0,0, 0,0,0, 0);
      tbl[15] = V(0,0,0, 0,0,0, 1,40,'h40, 0,0, 1, 0,0,0, 0,0,0, B40);
      tbl[16] = V(0,0,0, 0,0,0, 0,0,0, 1,40, 1, 1,40,'h40, 0,0,0, B40);
      tbl[17] = V(0,0,0, 0,0,0, 0,0,0, 0,0, 1, 0,0,0, 0,0,0, B40);
      tbl[18] = V(0,0,0, 0,0,0, 1,40,'h41, 0,0, 1, 0,0,0, 0,0,0, B40);
      tbl[19] = V(0,0,0, 0,0,0, 0,0,0, 0,0, 1, 1,40,'h41, 0,0,0, B40);
      tbl[20] = idle;
      tbl[21] = V(1,1,1, 1,2,2, 1,50,'h50, 0,0, 1, 1,1,1, 1,2,2, 0);
      tbl[22] = V(0,0,0, 0,0,0, 1,51,'h51, 0,0, 1, 1,50,'h50, 0,0,0, 0);
      tbl[23] = V(0,0,0, 0,0,0, 1,52,'h52, 0,0, 1, 1,51,'h51, 0,0,0, 0);
      tbl[24] = V(0,0,0, 0,0,0, 0,0,0, 0,0, 1, 1,52,'h52, 0,0,0, 0);
      tbl[25] = V(0,0,0, 0,0,0, 1,0,'h99, 1,0, 1, 0,0,0, 0,0,0, 0);
      tbl[26] = V(0,0,0, 0,0,0, 0,0,0, 0,0, 1, 1,0,'h99, 0,0,0, 0);
      tbl[27] = idle;

      rst_n = 1'b0;
      drive(idle);
      #2;
      compare(idle);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++)
         cyc(tbl[i]);
      chk("rf_x5", 64'(rf[5]), 64'h22);

      // Fill FIFO and scoreboard, then reset mid-cycle.
      cyc(V(1,1,1, 1,2,2, 1,7,'h70, 1,1, 1, 1,1,1, 1,2,2, 0));
      cyc(V(1,1,1, 1,2,2, 1,8,'h80, 1,2, 1, 1,1,1, 1,2,2, 64'h2));
      drive(V(1,1,1, 1,2,2, 0,0,0, 0,0, 0, 1,1,1, 1,2,2, 64'h6));
      #3;
      chk("full_ready", 64'(apu_ready_o), 64'h0);
      chk("full_pend", pending_o, 64'h6);
      drive(idle);
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(apu_ready_o), 64'h1);
      chk("rst_pend", pending_o, 64'h0);
      chk("rst_we_a", 64'(we_a_o), 64'h0);
      chk("rst_we_b", 64'(we_b_o), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic against a queue/scoreboard model.
      pm = '0;
      for (int n = 0; n < 3000; n++) begin
         vec_t v;
         ent_t h;
         logic pop;
         v = idle;
         v.ex_we  = ($urandom_range(0, 99) < 55);
         v.ex_a   = AW'($urandom);
         v.ex_d   = $urandom;
         v.lsu_we = ($urandom_range(0, 99) < 55);
         v.lsu_a  = AW'($urandom);
         v.lsu_d  = $urandom;
         v.av     = ($urandom_range(0, 99) < 60);
         v.aa     = AW'($urandom_range(0, 7));
         v.ad     = $urandom;
         v.iss    = ($urandom_range(0, 99) < 40);
         v.ia     = AW'($urandom_range(0, 7));
         v.rdy    = (q.size() < DEPTH);
         pop = 1'b0;
         if (q.size() > 0) h = q[0];
         else begin
            h.a = '0;
            h.d = '0;
         end
         v.wa = v.ex_we;
         v.a_a = v.ex_a;
         v.a_d = v.ex_d;
         if (!v.ex_we && q.size() > 0) begin
            v.wa = 1'b1;
            v.a_a = h.a;
            v.a_d = h.d;
            pop = 1'b1;
         end
         v.wb = v.lsu_we;
         v.b_a = v.lsu_a;
         v.b_d = v.lsu_d;
         if (v.ex_we && !v.lsu_we && q.size() > 0) begin
            v.wb = 1'b1;
            v.b_a = h.a;
            v.b_d = h.d;
            pop = 1'b1;
         end
         v.pend = pm;
         cyc(v);
         if (pop) begin
            pm[h.a] = 1'b0;
            void'(q.pop_front());
         end
         if (v.iss && v.ia != 0) pm[v.ia] = 1'b1;
         if (v.av && v.rdy) begin
            ent_t e;
            e.a = v.aa;
            e.d = v.ad;
            q.push_back(e);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
